// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined adder.
// Stage payloads are sized for the widest supported build.
package pipe_adder_pkg;

  localparam int MAX_W = 64;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             carry;
    logic [MAX_W-1:0] a_hi;
    logic [MAX_W-1:0] b_hi;
  } stage_t;

endpackage

// File: rtl/pipe_adder_seg.sv
// One carry-chain segment: SEG ripple bits, each a pair of
// half-adder cells (AND/XOR) with an OR merging the two carries.
module pipe_adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0]   c;
  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG-1:0] g2;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      p[i]     = a[i] ^ b[i];
      g[i]     = a[i] & b[i];
      s[i]     = p[i] ^ c[i];
      g2[i]    = p[i] & c[i];
      c[i+1]   = g[i] | g2[i];
    end
    cout = c[SEG];
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, STAGES carry segments, valid/ready both sides.
// Define PIPE_ADDER_STAT_EN to add the saturating result_cnt output.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_ADDER_STAT_EN
  ,
  output logic [15:0]      result_cnt
`endif
);

  localparam int SEG = seg_w(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH ||
      WIDTH % STAGES != 0 || WIDTH > MAX_W) begin : g_bad_cfg
    $error("pipe_adder: illegal WIDTH/STAGES");
  end

  stage_t [STAGES-1:0]          pl_q;
  stage_t [STAGES-1:0]          pl_d;
  stage_t [STAGES-1:0]          src;
  logic   [STAGES-1:0]          v_q;
  logic   [STAGES-1:0]          v_d;
  logic   [STAGES-1:0]          vin;
  logic   [STAGES:0]            adv;
  logic   [STAGES-1:0][SEG-1:0] seg_s;
  logic   [STAGES-1:0]          seg_co;

  // Stage k sees either fresh operands or the previous stage register.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src[k] = '{
        sum:   '0,
        carry: 1'b0,
        a_hi:  MAX_W'(a),
        b_hi:  MAX_W'(b)
      };
      assign vin[k] = in_valid;
    end else begin : g_rest
      assign src[k] = pl_q[k-1];
      assign vin[k] = v_q[k-1];
    end

    pipe_adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .a    (src[k].a_hi[k*SEG +: SEG]),
      .b    (src[k].b_hi[k*SEG +: SEG]),
      .cin  (src[k].carry),
      .s    (seg_s[k]),
      .cout (seg_co[k])
    );
  end

  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end

    v_d  = v_q;
    pl_d = pl_q;
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) begin
        v_d[k] = vin[k];
        if (vin[k]) begin
          pl_d[k] = src[k];
          pl_d[k].sum[k*SEG +: SEG] = seg_s[k];
          pl_d[k].carry = seg_co[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      pl_q <= '0;
    end else begin
      v_q  <= v_d;
      pl_q <= pl_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = pl_q[STAGES-1].sum[WIDTH-1:0];
  assign carry     = pl_q[STAGES-1].carry;

  // Payload bits above WIDTH and the trailing a/b copies are never read.
  logic unused_pl;
  assign unused_pl = ^pl_q;

`ifdef PIPE_ADDER_STAT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign result_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: driver pushes (a+b) expectations,
// an independent monitor pops them on every output handshake.
module tb_pipe_adder;

  parameter int W = 8;
  parameter int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         out_valid;
`ifdef PIPE_ADDER_STAT_EN
  logic [15:0]  result_cnt;
`endif

  pipe_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a_i),
    .b          (b_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .carry      (carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef PIPE_ADDER_STAT_EN
    ,
    .result_cnt (result_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   lat_chk = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)",
               nm, got, want, $time);
    end
  endtask

  // Call at a falling edge; returns at the next falling edge.
  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      output int waits);
    exp_t       e;
    logic [W:0] r;
    waits    = 0;
    a_i      = x;
    b_i      = y;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready low %0d cycles", waits);
    end else begin
      r       = {1'b0, x} + {1'b0, y};
      e.sum   = r[W-1:0];
      e.carry = r[W];
      e.cyc   = cyc;
      exp_q.push_back(e);
      pushed++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_in_ready", in_ready, 1);
    hs     = 0;
    pushed = 0;
    popped = 0;
    rst    = 1'b0;
  endtask

  // Monitor: sample well after the driver's falling-edge updates.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: sum %0h carry %0b, none pending",
                   sum, carry);
        end else begin
          e = exp_q.pop_front();
          popped++;
          chk("sum", sum, e.sum);
          chk("carry", carry, e.carry);
          if (lat_chk) chk("latency", cyc - e.cyc, S);
        end
      end
    end
  end

  // Random backpressure, changed mid-cycle so it never races the driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] ones;
  logic [W-1:0] vec_a [4];
  logic [W-1:0] vec_b [4];
  logic [W-1:0] hold_sum;
  int           w;
  int           acc;

  initial begin
    ones     = '1;
    vec_a[0] = W'('h3C); vec_b[0] = W'('h05);
    vec_a[1] = W'('h0F); vec_b[1] = W'('h01);
    vec_a[2] = ones;     vec_b[2] = W'(1);
    vec_a[3] = ones;     vec_b[3] = ones;

    repeat (3) @(negedge clk);
    do_reset();

    // Isolated ops with out_ready high: exact latency.
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vec_a[i], vec_b[i], w);
      repeat (S + 1) @(negedge clk);
    end

    // Backpressure: fill the pipe, then hold a further op.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < S; i++) begin
      send(W'($urandom), W'($urandom), w);
      if (w == 0) acc++;
    end
    chk("bp_accepts", acc, S);
    a_i      = W'($urandom);
    b_i      = W'($urandom);
    in_valid = 1'b1;
    #1;
    hold_sum = exp_q[0].sum;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum_stable", sum, hold_sum);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(a_i, b_i, w);
    send(W'($urandom), W'($urandom), w);
    repeat (S + 2) @(negedge clk);
    chk("bp_drained", exp_q.size(), 0);

    // Streaming: one accept per cycle, results at full rate.
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(W'($urandom), W'($urandom), w);
      chk("stream_stall", w, 0);
    end
    repeat (S + 2) @(negedge clk);

    // Random gaps and random backpressure.
    lat_chk    = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(W'($urandom), W'($urandom), w);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (S + 3) @(negedge clk);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_no_dup_or_loss", popped, pushed);

    // Reset with two ops in flight; nothing stale may follow.
    lat_chk = 1'b1;
    send(W'($urandom), W'($urandom), w);
    send(W'($urandom), W'($urandom), w);
    do_reset();
    repeat (S + 3) @(negedge clk);
    send(vec_a[2], vec_b[2], w);
    send(vec_a[0], vec_b[0], w);
    repeat (S + 3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_count", popped, pushed);
`ifdef PIPE_ADDER_STAT_EN
    chk("result_cnt", result_cnt, 16'(hs));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
